memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
//  Responder side of the datapath memory interface: accepts instruction-fetch and data load/store requests,
//  serialises them onto one single-ported RAM (ramstate handshake), returns one-cycle ihit/dhit pulses with data.
//  Sits between datapath/control (consumers of ihit/dhit) and the RAM model. Data requests have priority.
// PARAMETERS
//  TIMEOUT_CYCLES  64            max cycles in a grant state without ACCESS before abort (>=2)
//  BAD_WORD        32'hBAD1BAD1  load value returned on aborted/errored access
// PORTS
//  CLK       in   1   clock; all state updates on rising edge
//  RST       in   1   synchronous, active-high reset
//  iREN      in   1   instruction fetch request (level, held until ihit)
//  iaddr     in   32  fetch address (word aligned)
//  dREN      in   1   data load request (level, held until dhit)
//  dWEN      in   1   data store request (level, held until dhit)
//  daddr     in   32  data address (word aligned)
//  dstore    in   32  store data
//  ihit      out  1   one-cycle pulse: iload valid
//  iload     out  32  fetched instruction, held until next ihit
//  dhit      out  1   one-cycle pulse: load data valid / store committed
//  dload     out  32  load data, held until next load dhit
//  ramREN    out  1   RAM read strobe
//  ramWEN    out  1   RAM write strobe
//  ramaddr   out  32  RAM address
//  ramstore  out  32  RAM write data
//  ramload   in   32  RAM read data, valid when ramstate==ACCESS
//  ramstate  in   2   ramstate_t: FREE, BUSY, ACCESS, ERROR
//  mem_err   out  1   sticky: set on timeout or ERROR, cleared only by RST
// BEHAVIOUR
//  Reset (sync, active-high, dominates): state=IDLE, counter=0, every output 0 incl. iload/dload/mem_err.
//  States: IDLE, DGRANT, IGRANT, RESP.
//  IDLE: dREN|dWEN -> DGRANT; else iREN -> IGRANT; else stay. Entering a grant latches addr, store data,
//   op (dWEN beats dREN if both high; store). Latched values drive ram* for the whole grant.
//  Grant: ramREN=op read, ramWEN=op write; counter +1 per cycle. Requester input changes ignored.
//   ramstate==ACCESS: capture ramload (reads) -> RESP.
//   ramstate==ERROR, or counter==TIMEOUT_CYCLES-1 without ACCESS: load=BAD_WORD, mem_err<=1 -> RESP.
//   FREE/BUSY: stay.
//  RESP (exactly 1 cycle): ram strobes 0. Pulse ihit or dhit for the served port; update iload/dload
//   (stores leave dload unchanged). -> IDLE unconditionally, giving a one-cycle bubble so a request
//   still held this cycle is not re-served. Earliest next grant two cycles after RESP.
//  Latency: ACCESS seen in cycle N -> hit in cycle N+1. Min request-to-hit is 3 cycles (IDLE, grant, RESP).
//  ihit and dhit are never high together; ram strobes are 0 outside grant states; REN/WEN never both high.
//  Simultaneous iREN and dREN/dWEN in IDLE: data served first; instruction served on the next IDLE pass.
//  Request dropped mid-grant: access completes, hit still pulses.
//  Reset mid-grant: RAM access abandoned, no hit, strobes low next cycle.
//  Counter: clog2(TIMEOUT_CYCLES)+1 bits, cleared on grant entry, saturates, no wrap.
// STRUCTURE
//  cpu_types_pkg: add memarb_state_t {IDLE, DGRANT, IGRANT, RESP}; reuse word_t and ramstate_t.
//   BAD_WORD default comes from the package constant MEM_BAD_WORD.
//  Interface: memory_arbiter_if, with modports arb (this block), dp (datapath) and ram.
//  Sub-module: none. Single FSM, counter and latch registers fit in one always_ff plus one always_comb.
// TESTING
//  1 Reset: RST high 2 cycles with iREN=1 -> all outputs 0. After release, IGRANT next cycle.
//  2 Fetch, RAM ACCESS on 3rd grant cycle, ramload=32'h3C010001 -> ihit pulses 1 cycle later,
//    iload=32'h3C010001; no second ihit while iREN held through RESP.
//  3 iREN=dREN=1 same cycle -> DGRANT first (ramaddr=daddr) and dhit; then IGRANT and ihit.
//    ihit/dhit never coincide.
//  4 Store daddr=32'h100, dstore=32'hDEADBEEF with dREN=1 too -> ramWEN=1, ramREN=0,
//    ramstore=32'hDEADBEEF; dhit pulses; dload unchanged.
//  5 ramstate held BUSY, TIMEOUT_CYCLES=8 -> abort after 8 grant cycles: dhit, dload=32'hBAD1BAD1,
//    mem_err=1 until RST. Same outcome when ramstate=ERROR on grant cycle 1.
//  6 RST asserted during DGRANT -> IDLE next cycle, strobes 0, no dhit; a pending iREN is then served normally.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: bus word, RAM handshake states and the memory arbiter FSM encoding.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DGRANT = 2'd1,
      IGRANT = 2'd2,
      RESP   = 2'd3
   } memarb_state_t;

   localparam word_t MEM_BAD_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/memory_arbiter_if.sv
// Datapath <-> arbiter <-> RAM signal bundle; one modport per party on the bus.
interface memory_arbiter_if;
   import cpu_types_pkg::*;

   logic      iREN;
   word_t     iaddr;
   logic      dREN;
   logic      dWEN;
   word_t     daddr;
   word_t     dstore;
   logic      ihit;
   word_t     iload;
   logic      dhit;
   word_t     dload;
   logic      mem_err;
   logic      ramREN;
   logic      ramWEN;
   word_t     ramaddr;
   word_t     ramstore;
   word_t     ramload;
   ramstate_t ramstate;

   modport arb (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output ihit, iload, dhit, dload, mem_err, ramREN, ramWEN, ramaddr, ramstore
   );

   modport dp (
      output iREN, iaddr, dREN, dWEN, daddr, dstore,
      input  ihit, iload, dhit, dload, mem_err
   );

   modport ram (
      input  ramREN, ramWEN, ramaddr, ramstore,
      output ramload, ramstate
   );

endinterface

// File: rtl/memory_arbiter.sv
// Serialises instruction fetches and data loads/stores onto one single-ported RAM.
// Data requests win; every access ends in a one-cycle RESP followed by an IDLE bubble.
module memory_arbiter
   import cpu_types_pkg::*;
#(
   parameter int    TIMEOUT_CYCLES = 64,
   parameter word_t BAD_WORD       = MEM_BAD_WORD
) (
   input  logic          CLK,
   input  logic          RST,
   memory_arbiter_if.arb mif
);

   localparam int                 CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

   memarb_state_t    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   word_t            addr_q, addr_d;
   word_t            store_q, store_d;
   logic             wr_q, wr_d;
   logic             is_data_q, is_data_d;
   word_t            iload_q, iload_d;
   word_t            dload_q, dload_d;
   logic             err_q, err_d;
   logic             in_grant;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         store_q   <= '0;
         wr_q      <= 1'b0;
         is_data_q <= 1'b0;
         iload_q   <= '0;
         dload_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         store_q   <= store_d;
         wr_q      <= wr_d;
         is_data_q <= is_data_d;
         iload_q   <= iload_d;
         dload_q   <= dload_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      store_d   = store_q;
      wr_d      = wr_q;
      is_data_d = is_data_q;
      iload_d   = iload_q;
      dload_d   = dload_q;
      err_d     = err_q;

      case (state_q)
         IDLE: begin
            if (mif.dREN || mif.dWEN) begin
               state_d   = DGRANT;
               addr_d    = mif.daddr;
               store_d   = mif.dstore;
               wr_d      = mif.dWEN;
               is_data_d = 1'b1;
               cnt_d     = '0;
            end else if (mif.iREN) begin
               state_d   = IGRANT;
               addr_d    = mif.iaddr;
               wr_d      = 1'b0;
               is_data_d = 1'b0;
               cnt_d     = '0;
            end
         end
         DGRANT, IGRANT: begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            // Load registers are updated on the way into RESP so the hit pulse sees fresh data.
            if (mif.ramstate == ACCESS) begin
               state_d = RESP;
               if (!wr_q) begin
                  if (is_data_q) dload_d = mif.ramload;
                  else           iload_d = mif.ramload;
               end
            end else if (mif.ramstate == ERROR || cnt_q == CNT_LAST) begin
               state_d = RESP;
               err_d   = 1'b1;
               if (!wr_q) begin
                  if (is_data_q) dload_d = BAD_WORD;
                  else           iload_d = BAD_WORD;
               end
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_grant     = (state_q == DGRANT) || (state_q == IGRANT);
      mif.ramREN   = in_grant && !wr_q;
      mif.ramWEN   = in_grant && wr_q;
      mif.ramaddr  = addr_q;
      mif.ramstore = store_q;
      mif.ihit     = (state_q == RESP) && !is_data_q;
      mif.dhit     = (state_q == RESP) && is_data_q;
      mif.iload    = iload_q;
      mif.dload    = dload_q;
      mif.mem_err  = err_q;
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: the bench plays both datapath and RAM, checks against hand values.
module tb_memory_arbiter;
   import cpu_types_pkg::*;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   n_cmp = 0;
   int   n_mis = 0;

   memory_arbiter_if mif ();

   memory_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .CLK (CLK),
      .RST (RST),
      .mif (mif)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Starts in a grant cycle; BUSY for waits cycles, then fin with ld; returns sampling the next state.
   task automatic run_grant(input int waits, input ramstate_t fin, input word_t ld);
      for (int i = 0; i < waits; i++) begin
         mif.ramstate = BUSY;
         tick();
      end
      mif.ramstate = fin;
      mif.ramload  = ld;
      tick();
      mif.ramstate = FREE;
      mif.ramload  = '0;
   endtask

   initial begin
      mif.iREN = 1'b1; mif.iaddr = 32'h40;
      mif.dREN = 1'b0; mif.dWEN = 1'b0; mif.daddr = '0; mif.dstore = '0;
      mif.ramload = '0; mif.ramstate = FREE;

      // 1: reset with a fetch pending
      tick(); tick();
      chk("rst_ihit",   32'(mif.ihit),    32'h0);
      chk("rst_dhit",   32'(mif.dhit),    32'h0);
      chk("rst_ren",    32'(mif.ramREN),  32'h0);
      chk("rst_wen",    32'(mif.ramWEN),  32'h0);
      chk("rst_addr",   mif.ramaddr,      32'h0);
      chk("rst_store",  mif.ramstore,     32'h0);
      chk("rst_iload",  mif.iload,        32'h0);
      chk("rst_dload",  mif.dload,        32'h0);
      chk("rst_err",    32'(mif.mem_err), 32'h0);
      RST = 1'b0;
      tick();
      chk("t1_igrant_ren",  32'(mif.ramREN), 32'h1);
      chk("t1_igrant_addr", mif.ramaddr,     32'h40);

      // 2: fetch, ACCESS on third grant cycle, iREN held through RESP
      tick();
      mif.ramstate = BUSY;
      tick();
      chk("t2_g3_ren",  32'(mif.ramREN), 32'h1);
      chk("t2_g3_ihit", 32'(mif.ihit),   32'h0);
      mif.ramstate = ACCESS; mif.ramload = 32'h3C010001;
      tick();
      mif.ramstate = FREE; mif.ramload = '0;
      chk("t2_ihit",     32'(mif.ihit),   32'h1);
      chk("t2_iload",    mif.iload,       32'h3C010001);
      chk("t2_resp_ren", 32'(mif.ramREN), 32'h0);
      tick();
      chk("t2_bubble_ihit", 32'(mif.ihit),   32'h0);
      chk("t2_bubble_ren",  32'(mif.ramREN), 32'h0);
      tick();
      chk("t2_regrant_ren", 32'(mif.ramREN), 32'h1);
      mif.iREN = 1'b0;
      run_grant(1, ACCESS, 32'h11111111);
      chk("t2_drop_ihit",  32'(mif.ihit), 32'h1);
      chk("t2_drop_iload", mif.iload,     32'h11111111);
      tick();

      // 3: simultaneous fetch and load -> data first
      mif.iREN = 1'b1; mif.iaddr = 32'h80;
      mif.dREN = 1'b1; mif.daddr = 32'h200;
      tick();
      chk("t3_dg_addr", mif.ramaddr,     32'h200);
      chk("t3_dg_ren",  32'(mif.ramREN), 32'h1);
      chk("t3_dg_wen",  32'(mif.ramWEN), 32'h0);
      run_grant(0, ACCESS, 32'hCAFEF00D);
      chk("t3_dhit",   32'(mif.dhit), 32'h1);
      chk("t3_nohit_i", 32'(mif.ihit), 32'h0);
      chk("t3_dload",  mif.dload,     32'hCAFEF00D);
      mif.dREN = 1'b0;
      tick();
      chk("t3_bubble_dhit", 32'(mif.dhit), 32'h0);
      tick();
      chk("t3_ig_addr", mif.ramaddr, 32'h80);
      run_grant(1, ACCESS, 32'h12345678);
      chk("t3_ihit",    32'(mif.ihit), 32'h1);
      chk("t3_nohit_d", 32'(mif.dhit), 32'h0);
      chk("t3_iload",   mif.iload,     32'h12345678);
      mif.iREN = 1'b0;
      tick();

      // 4: store with dREN also high -> write wins, dload untouched
      mif.dREN = 1'b1; mif.dWEN = 1'b1; mif.daddr = 32'h100; mif.dstore = 32'hDEADBEEF;
      tick();
      chk("t4_wen",   32'(mif.ramWEN), 32'h1);
      chk("t4_ren",   32'(mif.ramREN), 32'h0);
      chk("t4_store", mif.ramstore,    32'hDEADBEEF);
      chk("t4_addr",  mif.ramaddr,     32'h100);
      run_grant(0, ACCESS, 32'h55555555);
      chk("t4_dhit",  32'(mif.dhit), 32'h1);
      chk("t4_dload", mif.dload,     32'hCAFEF00D);
      mif.dREN = 1'b0; mif.dWEN = 1'b0;
      tick();

      // 5a: RAM stuck BUSY -> abort on eighth grant cycle
      mif.dREN = 1'b1; mif.daddr = 32'h300;
      tick();
      mif.ramstate = BUSY;
      for (int i = 0; i < 7; i++) tick();
      chk("t5_g8_ren",  32'(mif.ramREN),  32'h1);
      chk("t5_g8_err",  32'(mif.mem_err), 32'h0);
      tick();
      mif.ramstate = FREE;
      chk("t5_to_dhit",  32'(mif.dhit),    32'h1);
      chk("t5_to_dload", mif.dload,        32'hBAD1BAD1);
      chk("t5_to_err",   32'(mif.mem_err), 32'h1);
      mif.dREN = 1'b0;
      tick(); tick();
      chk("t5_err_sticky", 32'(mif.mem_err), 32'h1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk("t5_err_clr", 32'(mif.mem_err), 32'h0);

      // 5b: ERROR on first grant cycle
      mif.dREN = 1'b1; mif.daddr = 32'h304;
      tick();
      run_grant(0, ERROR, 32'h0);
      chk("t5_er_dhit",  32'(mif.dhit),    32'h1);
      chk("t5_er_dload", mif.dload,        32'hBAD1BAD1);
      chk("t5_er_err",   32'(mif.mem_err), 32'h1);
      mif.dREN = 1'b0;
      tick();

      // 6: reset during DGRANT, then the pending fetch is served
      mif.dREN = 1'b1; mif.daddr = 32'h400;
      mif.iREN = 1'b1; mif.iaddr = 32'h500;
      tick();
      chk("t6_dg_ren", 32'(mif.ramREN), 32'h1);
      mif.ramstate = BUSY;
      RST = 1'b1;
      tick();
      RST = 1'b0; mif.dREN = 1'b0; mif.ramstate = FREE;
      chk("t6_rst_ren",  32'(mif.ramREN), 32'h0);
      chk("t6_rst_dhit", 32'(mif.dhit),   32'h0);
      tick();
      chk("t6_ig_addr", mif.ramaddr,     32'h500);
      chk("t6_ig_dhit", 32'(mif.dhit),   32'h0);
      run_grant(0, ACCESS, 32'h0BADF00D);
      chk("t6_ihit",  32'(mif.ihit), 32'h1);
      chk("t6_dhit",  32'(mif.dhit), 32'h0);
      chk("t6_iload", mif.iload,     32'h0BADF00D);
      mif.iREN = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
